// File: rtl/sc_speed_pkg.sv
// ---------------------------------------------------------------------------
// sc_speed_pkg
//   Shared definitions for the speed timebase and the comparator it feeds.
//   - default width/step constants (the data width must match the comparator)
//   - FSM state encoding for the counter
//   - helper that sizes a counter able to hold 0..n-1 (never narrower than 1)
// ---------------------------------------------------------------------------
package sc_speed_pkg;

  localparam int SC_DATAWIDTH   = 24;
  localparam int SC_LEVELWIDTH  = 3;
  localparam int SC_TICKSPERLVL = 8;
  localparam int SC_MAXLEVEL    = 7;

  // Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sc_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sc_speed_counter_if.sv
// ---------------------------------------------------------------------------
// sc_speed_counter_if
//   Bundle between the speed counter and its environment (control inputs,
//   comparator terminal flag, count/tick/level/status outputs).
//   modport master : the speed counter side
//   modport slave  : the environment / comparator side
// ---------------------------------------------------------------------------
interface sc_speed_counter_if
  import sc_speed_pkg::*;
#(
  parameter int DW = SC_DATAWIDTH,
  parameter int LW = SC_LEVELWIDTH
);

  logic          SC_SPEEDCOUNTER_start_InLow;
  logic          SC_SPEEDCOUNTER_pause_InLow;
  logic          SC_SPEEDCOUNTER_T0_InLow;
  logic [DW-1:0] SC_SPEEDCOUNTER_data_OutBUS;
  logic          SC_SPEEDCOUNTER_tick_OutHigh;
  logic [LW-1:0] SC_SPEEDCOUNTER_level_OutBUS;
  logic          SC_SPEEDCOUNTER_running_OutHigh;
  logic          SC_SPEEDCOUNTER_overflow_OutHigh;

  modport master (
    input  SC_SPEEDCOUNTER_start_InLow,
    input  SC_SPEEDCOUNTER_pause_InLow,
    input  SC_SPEEDCOUNTER_T0_InLow,
    output SC_SPEEDCOUNTER_data_OutBUS,
    output SC_SPEEDCOUNTER_tick_OutHigh,
    output SC_SPEEDCOUNTER_level_OutBUS,
    output SC_SPEEDCOUNTER_running_OutHigh,
    output SC_SPEEDCOUNTER_overflow_OutHigh
  );

  modport slave (
    output SC_SPEEDCOUNTER_start_InLow,
    output SC_SPEEDCOUNTER_pause_InLow,
    output SC_SPEEDCOUNTER_T0_InLow,
    input  SC_SPEEDCOUNTER_data_OutBUS,
    input  SC_SPEEDCOUNTER_tick_OutHigh,
    input  SC_SPEEDCOUNTER_level_OutBUS,
    input  SC_SPEEDCOUNTER_running_OutHigh,
    input  SC_SPEEDCOUNTER_overflow_OutHigh
  );

endinterface

// File: rtl/sc_speed_levelctr.sv
// ---------------------------------------------------------------------------
// sc_speed_levelctr
//   Counts terminal ticks and steps a saturating speed level every
//   TICKSPERLVL ticks.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   tick  : a terminal is being taken this cycle (level moves on the same edge
//           the registered tick rises)
//   clear : start of a new run, zeroes tick count and level
//   level : current speed level
// ---------------------------------------------------------------------------
module sc_speed_levelctr
  import sc_speed_pkg::*;
#(
  parameter int LEVELWIDTH  = SC_LEVELWIDTH,
  parameter int TICKSPERLVL = SC_TICKSPERLVL,
  parameter int MAXLEVEL    = SC_MAXLEVEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  clear,
  output logic [LEVELWIDTH-1:0] level
);

  localparam int TCW = cnt_width(TICKSPERLVL);

  logic [TCW-1:0]        tickcnt_q, tickcnt_d;
  logic [LEVELWIDTH-1:0] level_q, level_d;

  // The tick count keeps wrapping after the level has saturated.
  always_comb begin
    tickcnt_d = tickcnt_q;
    level_d   = level_q;
    if (clear) begin
      tickcnt_d = '0;
      level_d   = '0;
    end else if (tick) begin
      if (tickcnt_q == TCW'(TICKSPERLVL - 1)) begin
        tickcnt_d = '0;
        if (level_q != LEVELWIDTH'(MAXLEVEL))
          level_d = level_q + LEVELWIDTH'(1);
      end else begin
        tickcnt_d = tickcnt_q + TCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tickcnt_q <= '0;
      level_q   <= '0;
    end else begin
      tickcnt_q <= tickcnt_d;
      level_q   <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/sc_speed_counter.sv
// ---------------------------------------------------------------------------
// sc_speed_counter
//   Free-running speed timebase. Drives its count to the speed comparator and
//   reacts to the comparator's active-low terminal flag: on terminal the count
//   restarts at 0 and a one-cycle tick is emitted; every TICKSPERLVL ticks the
//   speed level steps up (saturating). A wrap without terminal sets a sticky
//   overflow flag.
//   SC_SPEEDCOUNTER_CLOCK_50     : clock, rising edge
//   SC_SPEEDCOUNTER_RESET_InHigh : synchronous active-high reset
//   sc_bus (master)              : start/pause/T0 in; data/tick/level/
//                                  running/overflow out (all registered)
// ---------------------------------------------------------------------------
module sc_speed_counter
  import sc_speed_pkg::*;
#(
  parameter int SPEEDCOUNTER_DATAWIDTH  = SC_DATAWIDTH,
  parameter int SPEEDCOUNTER_LEVELWIDTH = SC_LEVELWIDTH,
  parameter int SPEEDCOUNTER_TICKSPERLVL = SC_TICKSPERLVL,
  parameter int SPEEDCOUNTER_MAXLEVEL   = SC_MAXLEVEL
) (
  input  logic               SC_SPEEDCOUNTER_CLOCK_50,
  input  logic               SC_SPEEDCOUNTER_RESET_InHigh,
  sc_speed_counter_if.master sc_bus
);

  localparam int DW = SPEEDCOUNTER_DATAWIDTH;

  sc_state_e     state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          tick_q, tick_d;
  logic          overflow_q, overflow_d;
  logic          running_q, running_d;
  logic          level_clear;

  // Comparator is combinational, so T0 already describes data_q this cycle.
  // A terminal coinciding with pause is finished (tick, count cleared) before
  // the pause takes effect.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    tick_d      = 1'b0;
    overflow_d  = overflow_q;
    level_clear = 1'b0;
    case (state_q)
      IDLE: begin
        data_d = '0;
        if (!sc_bus.SC_SPEEDCOUNTER_start_InLow) begin
          state_d     = RUN;
          overflow_d  = 1'b0;
          level_clear = 1'b1;
        end
      end
      RUN: begin
        if (!sc_bus.SC_SPEEDCOUNTER_T0_InLow) begin
          data_d = '0;
          tick_d = 1'b1;
        end else if (data_q == {DW{1'b1}}) begin
          data_d     = '0;
          overflow_d = 1'b1;
        end else begin
          data_d = data_q + DW'(1);
        end
        if (!sc_bus.SC_SPEEDCOUNTER_pause_InLow)
          state_d = PAUSE;
      end
      PAUSE: begin
        if (sc_bus.SC_SPEEDCOUNTER_pause_InLow)
          state_d = RUN;
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
      end
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge SC_SPEEDCOUNTER_CLOCK_50) begin
    if (SC_SPEEDCOUNTER_RESET_InHigh) begin
      state_q    <= IDLE;
      data_q     <= '0;
      tick_q     <= 1'b0;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      tick_q     <= tick_d;
      overflow_q <= overflow_d;
      running_q  <= running_d;
    end
  end

  sc_speed_levelctr #(
    .LEVELWIDTH  (SPEEDCOUNTER_LEVELWIDTH),
    .TICKSPERLVL (SPEEDCOUNTER_TICKSPERLVL),
    .MAXLEVEL    (SPEEDCOUNTER_MAXLEVEL)
  ) u_levelctr (
    .clk   (SC_SPEEDCOUNTER_CLOCK_50),
    .rst   (SC_SPEEDCOUNTER_RESET_InHigh),
    .tick  (tick_d),
    .clear (level_clear),
    .level (sc_bus.SC_SPEEDCOUNTER_level_OutBUS)
  );

  assign sc_bus.SC_SPEEDCOUNTER_data_OutBUS      = data_q;
  assign sc_bus.SC_SPEEDCOUNTER_tick_OutHigh     = tick_q;
  assign sc_bus.SC_SPEEDCOUNTER_running_OutHigh  = running_q;
  assign sc_bus.SC_SPEEDCOUNTER_overflow_OutHigh = overflow_q;

endmodule

// File: tb/tb_sc_speed_counter.sv
// ---------------------------------------------------------------------------
// tb_sc_speed_counter
//   Bench for sc_speed_counter with a 4-bit count, 2 ticks per level, level
//   saturating at 3 and a comparator model whose terminal value is 5 (or that
//   never matches when never_match is set).
// ---------------------------------------------------------------------------
module tb_sc_speed_counter;

  localparam int          DW       = 4;
  localparam int          LW       = 3;
  localparam logic [3:0]  TERMINAL = 4'd5;

  typedef struct {
    logic [3:0] data;
    logic       tick;
    logic [2:0] level;
    logic       running;
    logic       overflow;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic never_match = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  sc_speed_counter_if #(.DW(DW), .LW(LW)) sc_bus ();

  sc_speed_counter #(
    .SPEEDCOUNTER_DATAWIDTH   (DW),
    .SPEEDCOUNTER_LEVELWIDTH  (LW),
    .SPEEDCOUNTER_TICKSPERLVL (2),
    .SPEEDCOUNTER_MAXLEVEL    (3)
  ) dut (
    .SC_SPEEDCOUNTER_CLOCK_50     (clk),
    .SC_SPEEDCOUNTER_RESET_InHigh (rst),
    .sc_bus                       (sc_bus.master)
  );

  // Combinational comparator model driving the active-low terminal flag.
  assign sc_bus.SC_SPEEDCOUNTER_T0_InLow =
    never_match ? 1'b1 : (sc_bus.SC_SPEEDCOUNTER_data_OutBUS != TERMINAL);

  always #5 clk = ~clk;

  task automatic checkField(input string tag, input string field,
                            input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s %s: got %0d expected %0d", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard: got empty queue expected an entry");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkField(e.tag, "data",     8'(sc_bus.SC_SPEEDCOUNTER_data_OutBUS),      8'(e.data));
      checkField(e.tag, "tick",     8'(sc_bus.SC_SPEEDCOUNTER_tick_OutHigh),     8'(e.tick));
      checkField(e.tag, "level",    8'(sc_bus.SC_SPEEDCOUNTER_level_OutBUS),     8'(e.level));
      checkField(e.tag, "running",  8'(sc_bus.SC_SPEEDCOUNTER_running_OutHigh),  8'(e.running));
      checkField(e.tag, "overflow", 8'(sc_bus.SC_SPEEDCOUNTER_overflow_OutHigh), 8'(e.overflow));
    end
  endtask

  // Drives one cycle of inputs, queues the outputs expected after the next
  // rising edge, then compares them just after that edge.
  task automatic applyStimulus(input logic r, input logic start_n, input logic pause_n,
                               input logic [3:0] d, input logic t, input logic [2:0] l,
                               input logic run, input logic ov, input string tag);
    exp_t e;
    rst = r;
    sc_bus.SC_SPEEDCOUNTER_start_InLow = start_n;
    sc_bus.SC_SPEEDCOUNTER_pause_InLow = pause_n;
    e.data = d; e.tick = t; e.level = l; e.running = run; e.overflow = ov; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    sc_bus.SC_SPEEDCOUNTER_start_InLow = 1'b1;
    sc_bus.SC_SPEEDCOUNTER_pause_InLow = 1'b1;
    $display("[TB] start");

    // Reset with start held low must stay idle.
    applyStimulus(1, 0, 1, 4'd0, 0, 3'd0, 0, 0, "reset0");
    applyStimulus(1, 0, 1, 4'd0, 0, 3'd0, 0, 0, "reset1");
    applyStimulus(0, 1, 1, 4'd0, 0, 3'd0, 0, 0, "idle");

    // Start, then count 0..5 with a tick each time the count returns to 0.
    // Level steps every 2nd tick (k=12, 24, 36) and saturates at 3.
    for (int k = 0; k <= 56; k++) begin
      logic [2:0] lvl;
      lvl = (k / 12 > 3) ? 3'd3 : 3'(k / 12);
      applyStimulus(0, (k == 0) ? 1'b0 : 1'b1, 1, 4'(k % 6),
                    (k % 6 == 0) && (k > 0), lvl, 1, 0, $sformatf("run k=%0d", k));
    end

    // Pause taken while count is 2 -> freezes at 3.
    applyStimulus(0, 1, 0, 4'd3, 0, 3'd3, 0, 0, "pause_enter");
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 0, 4'd3, 0, 3'd3, 0, 0, $sformatf("pause_hold%0d", i));
    applyStimulus(0, 1, 1, 4'd3, 0, 3'd3, 1, 0, "pause_release");
    applyStimulus(0, 1, 1, 4'd4, 0, 3'd3, 1, 0, "resume4");
    applyStimulus(0, 1, 1, 4'd5, 0, 3'd3, 1, 0, "resume5");
    applyStimulus(0, 1, 1, 4'd0, 1, 3'd3, 1, 0, "resume_tick");
    applyStimulus(0, 1, 1, 4'd1, 0, 3'd3, 1, 0, "resume1");

    // Pause asserted in the terminal cycle: tick still issued, then frozen.
    applyStimulus(0, 1, 1, 4'd2, 0, 3'd3, 1, 0, "pre2");
    applyStimulus(0, 1, 1, 4'd3, 0, 3'd3, 1, 0, "pre3");
    applyStimulus(0, 1, 1, 4'd4, 0, 3'd3, 1, 0, "pre4");
    applyStimulus(0, 1, 1, 4'd5, 0, 3'd3, 1, 0, "pre5");
    applyStimulus(0, 1, 0, 4'd0, 1, 3'd3, 0, 0, "term_pause");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 4'd0, 0, 3'd3, 0, 0, $sformatf("term_pause_hold%0d", i));
    applyStimulus(0, 1, 1, 4'd0, 0, 3'd3, 1, 0, "term_release");
    applyStimulus(0, 1, 1, 4'd1, 0, 3'd3, 1, 0, "term_resume1");

    // Comparator never matches: count runs past 5 and wraps with overflow.
    never_match = 1'b1;
    for (int v = 2; v <= 15; v++)
      applyStimulus(0, 1, 1, 4'(v), 0, 3'd3, 1, 0, $sformatf("nomatch%0d", v));
    applyStimulus(0, 1, 1, 4'd0, 0, 3'd3, 1, 1, "wrap");
    applyStimulus(0, 1, 1, 4'd1, 0, 3'd3, 1, 1, "wrap_sticky");

    // Reset mid-run clears everything.
    applyStimulus(1, 1, 1, 4'd0, 0, 3'd0, 0, 0, "reset_run");
    never_match = 1'b0;
    applyStimulus(0, 1, 1, 4'd0, 0, 3'd0, 0, 0, "idle2");
    applyStimulus(0, 0, 1, 4'd0, 0, 3'd0, 1, 0, "restart");
    for (int v = 1; v <= 5; v++)
      applyStimulus(0, 1, 1, 4'(v), 0, 3'd0, 1, 0, $sformatf("rerun%0d", v));
    // Reset in the terminal cycle drops the pending tick.
    applyStimulus(1, 1, 1, 4'd0, 0, 3'd0, 0, 0, "reset_drop_tick");
    applyStimulus(0, 1, 1, 4'd0, 0, 3'd0, 0, 0, "idle3");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
